unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (I-port) and the MEM-stage load/store requester (D-port) of the 5-stage RV32 pipeline.
- Grants one requester at a time and holds the memory handshake stable until the transaction completes.
- Returns the read data to the granted port.
- Drives per-port stall outputs for the hazard logic, which holds PC and the pipeline registers.
- D-port has priority by default; a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_WIDTH, 32, address width of both ports and the memory.
DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 wide.
STARVE_LIMIT, 4, consecutive D grants, issued while i_req is pending, after which I wins the next arbitration.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
i_req  in  1  fetch read request; level, held until i_valid.
i_addr  in  ADDR_WIDTH  fetch address.
i_rdata  out  DATA_WIDTH  fetch data; valid when i_valid=1.
i_valid  out  1  one-cycle completion pulse.
i_stall  out  1  i_req && !i_valid.
d_req  in  1  data request; level, held until d_valid.
d_we  in  1  1=store, 0=load.
d_addr  in  ADDR_WIDTH  data address.
d_wdata  in  DATA_WIDTH  store data.
d_wstrb  in  DATA_WIDTH/8  store byte enables.
d_rdata  out  DATA_WIDTH  load data; valid when d_valid=1.
d_valid  out  1  one-cycle completion pulse.
d_stall  out  1  d_req && !d_valid.
mem_req  out  1  memory request.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_wstrb  out  DATA_WIDTH/8  memory byte enables.
mem_ack  in  1  memory completion, one cycle; mem_rdata is valid in the same cycle.
mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- Reset: all outputs return to zero on the next rising edge; state=IDLE, starve_cnt=0.
- IDLE arbitration:
  - d_req && (!i_req || starve_cnt<STARVE_LIMIT) -> GRANT_D.
  - Else if i_req -> GRANT_I.
  - Else stay in IDLE.
  - On a D grant with i_req high, starve_cnt increments (saturating at STARVE_LIMIT).
  - On an I grant, starve_cnt clears to 0.
  - A D grant with i_req low leaves starve_cnt unchanged.
- On a grant edge, register mem_addr, mem_we, mem_wdata and mem_wstrb from the winning port; the I-port forces we=0 and wstrb=0.
- mem_req=1 exactly while in GRANT_x. Memory outputs stay stable until mem_ack.
- GRANT_x with mem_ack=1:
  - Load mem_rdata into x_rdata, except on a D store.
  - Go to RESP_x.
- GRANT_x with mem_ack=0: stay in GRANT_x, with no timeout.
- RESP_x: x_valid=1 for exactly this cycle, then IDLE. The requester may drop or change its request in this cycle.
- Timing: minimum latency is 2 cycles from a request accepted in IDLE at cycle N (mem_req at N+1, ack at N+1, valid at N+2). The next arbitration happens at N+3.
- Stores: d_valid pulses; d_rdata keeps its previous value.
- i_rdata and d_rdata hold their value between transactions.
- mem_ack outside GRANT_x is ignored.
- A port's request change while it is not granted is ignored until the next IDLE arbitration.
- Reset while in GRANT_x abandons the transaction:
  - No valid pulse is issued.
  - mem_req=0 from the next edge.
  - A late mem_ack is ignored.
  - starve_cnt is cleared.
- Reset while in RESP_x suppresses nothing already emitted; state becomes IDLE.
- Simultaneous i_req and d_req from reset go to GRANT_D.

Test Plan:
- I-only read, i_addr=0x10 at cycle 0, mem_ack in the mem_req cycle, mem_rdata=0x00500093:
  - Required: mem_req=1 at cycle 1; i_valid=1 at cycle 2 with i_rdata=0x00500093.
  - Required: i_stall=1 at cycles 0-1 and 0 at cycle 2.
- i_req (0x20) and d_req load (0x100) both at cycle 0, immediate acks:
  - Required: GRANT_D at cycle 1 with mem_addr=0x100; d_valid at cycle 2.
  - Required: I arbitrated at cycle 3; mem_addr=0x20 at cycle 4; i_valid at cycle 5.
- D store of 0xDEADBEEF to 0x200 with wstrb=4'b0011, mem_ack 3 cycles after mem_req rises:
  - Required: mem_req, mem_we=1, mem_addr, mem_wdata and mem_wstrb stable for 4 cycles.
  - Required: one d_valid pulse; d_rdata unchanged.
- STARVE_LIMIT=4 with i_req and d_req held continuously, requesters re-asserting after each valid:
  - Required grant order: D,D,D,D,I,D,D,D,D,I.
- Reset for 1 cycle while in GRANT_I with mem_ack=0, then mem_ack pulsed 2 cycles later:
  - Required: mem_req=0 after the reset edge; no i_valid; state IDLE.
- Spurious mem_ack in IDLE with no requests:
  - Required: no valid pulse; i_rdata and d_rdata unchanged; mem_req stays 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port memory between the instruction-fetch
// port (I) and the load/store port (D) of the RV32 pipeline.
// D normally wins. A starvation counter makes sure fetch still makes progress.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch port
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_valid,
  output logic                    i_stall,
  // load/store port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_valid,
  output logic                    d_stall,
  // memory side
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    starve_cnt_q, starve_cnt_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    starved;

  // I has waited through STARVE_LIMIT D grants and must win the next arbitration
  assign starved = (starve_cnt_q >= STARVE_MAX);

  // Next-state logic: arbitration in IDLE, wait for ack in GRANT, one-cycle response
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || !starved)) begin
          state_d     = GRANT_D;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          // Only D grants that overtake a waiting fetch count toward starvation
          if (i_req && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
          end
        end else if (i_req) begin
          state_d      = GRANT_I;
          mem_addr_d   = i_addr;
          mem_we_d     = 1'b0;
          mem_wdata_d  = '0;
          mem_wstrb_d  = '0;
          starve_cnt_d = '0;
        end
      end
      GRANT_I: begin
        if (mem_ack) begin
          i_rdata_d = mem_rdata;
          state_d   = RESP_I;
        end
      end
      GRANT_D: begin
        if (mem_ack) begin
          // A store leaves the last load data visible on d_rdata
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  assign i_valid = (state_q == RESP_I);
  assign d_valid = (state_q == RESP_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a table of single-shot
// request patterns, then hand-written sequences for delayed acks, spurious
// acks, reset mid-transaction and fetch starvation.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // memory responder: auto mode acks in the request cycle, manual mode is scripted
  logic        manual_mode;
  logic        mem_ack_man;
  logic [31:0] mem_rdata_man;

  int checks   = 0;
  int failures = 0;

  // scoreboard: per-port expected read data, plus the order valids appeared in
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [7:0]  grant_log[$];
  logic [31:0] i_model;
  logic [31:0] d_model;
  logic [31:0] popped;

  typedef struct {
    bit          i_en;
    logic [31:0] i_a;
    bit          d_en;
    bit          d_wr;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic [3:0]  d_ws;
    int          exp_i_cyc;
    int          exp_d_cyc;
    logic [31:0] exp_addr1;
    logic        exp_we1;
    int          addr2_cyc;
    logic [31:0] exp_addr2;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] memModel(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign mem_ack   = manual_mode ? mem_ack_man   : mem_req;
  assign mem_rdata = manual_mode ? mem_rdata_man : memModel(mem_addr);

  unified_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_valid  (i_valid),
    .i_stall  (i_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .d_stall  (d_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  // free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // pops the scoreboard whenever a port completes and checks its read data
  always @(negedge clk) begin
    if (i_valid) begin
      grant_log.push_back("I");
      if (i_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL i_valid_unexpected: got i_valid=1, want 0");
      end else begin
        popped = i_exp_q.pop_front();
        checkOutput("sb_i_rdata", i_rdata, popped);
      end
    end
    if (d_valid) begin
      grant_log.push_back("D");
      if (d_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL d_valid_unexpected: got d_valid=1, want 0");
      end else begin
        popped = d_exp_q.pop_front();
        checkOutput("sb_d_rdata", d_rdata, popped);
      end
    end
  end

  // drives one table row from an IDLE cycle and checks grant timing and stalls
  task automatic applyStimulus(input vec_t v, input int k);
    int  i_seen;
    int  d_seen;
    bit  done;
    @(posedge clk); #1;
    i_req   = v.i_en;
    i_addr  = v.i_a;
    d_req   = v.d_en;
    d_we    = v.d_wr;
    d_addr  = v.d_a;
    d_wdata = v.d_wd;
    d_wstrb = v.d_ws;
    if (v.i_en) begin
      i_model = memModel(v.i_a);
      i_exp_q.push_back(i_model);
    end
    if (v.d_en) begin
      if (!v.d_wr) d_model = memModel(v.d_a);
      d_exp_q.push_back(d_model);
    end
    i_seen = -1;
    d_seen = -1;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (v.i_en && i_seen < 0)
        checkOutput($sformatf("v%0d_i_stall_c%0d", k, c), {31'b0, i_stall}, {31'b0, c != v.exp_i_cyc});
      if (v.d_en && d_seen < 0)
        checkOutput($sformatf("v%0d_d_stall_c%0d", k, c), {31'b0, d_stall}, {31'b0, c != v.exp_d_cyc});
      if (c == 1) begin
        checkOutput($sformatf("v%0d_mem_req_c1", k), {31'b0, mem_req}, 32'd1);
        checkOutput($sformatf("v%0d_mem_addr_c1", k), mem_addr, v.exp_addr1);
        checkOutput($sformatf("v%0d_mem_we_c1", k), {31'b0, mem_we}, {31'b0, v.exp_we1});
      end
      if (c == v.addr2_cyc) begin
        checkOutput($sformatf("v%0d_mem_req_c%0d", k, c), {31'b0, mem_req}, 32'd1);
        checkOutput($sformatf("v%0d_mem_addr_c%0d", k, c), mem_addr, v.exp_addr2);
        checkOutput($sformatf("v%0d_mem_we_c%0d", k, c), {31'b0, mem_we}, 32'd0);
        checkOutput($sformatf("v%0d_mem_wstrb_c%0d", k, c), {28'b0, mem_wstrb}, 32'd0);
      end
      if (i_valid && i_seen < 0) begin
        i_seen = c;
        i_req  = 1'b0;
      end
      if (d_valid && d_seen < 0) begin
        d_seen = c;
        d_req  = 1'b0;
        d_we   = 1'b0;
      end
      if ((!v.i_en || i_seen >= 0) && (!v.d_en || d_seen >= 0)) done = 1'b1;
    end
    if (v.i_en) checkOutput($sformatf("v%0d_i_valid_cycle", k), i_seen, v.exp_i_cyc);
    if (v.d_en) checkOutput($sformatf("v%0d_d_valid_cycle", k), d_seen, v.exp_d_cyc);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // hard stop in case something hangs outside the bounded loops
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // main test sequence
  initial begin
    int          pulses;
    int          valid_cyc;
    int          n;
    string       exp_order;
    logic [7:0]  exp_ch;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    manual_mode = 1'b0; mem_ack_man = 1'b0; mem_rdata_man = '0;
    i_model = '0; d_model = '0;

    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0,    2, -1, 32'h10,  1'b0, -1, 32'h0};
    vecs[1] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0,        4'h0,    5,  2, 32'h100, 1'b0,  4, 32'h20};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h144, 32'h0,        4'h0,   -1,  2, 32'h144, 1'b0, -1, 32'h0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 4'hF,   -1,  2, 32'h300, 1'b1, -1, 32'h0};
    vecs[4] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h208, 32'hCAFEF00D, 4'b1100, 5,  2, 32'h208, 1'b1,  4, 32'h40};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    checkOutput("rst_i_valid", {31'b0, i_valid}, 32'd0);
    checkOutput("rst_d_valid", {31'b0, d_valid}, 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);

    // table-driven single-shot patterns with immediate acks
    for (int k = 0; k < 5; k++) applyStimulus(vecs[k], k);

    // store with mem_ack three cycles after mem_req rises
    @(posedge clk); #1;
    manual_mode   = 1'b1;
    mem_ack_man   = 1'b0;
    mem_rdata_man = 32'hBAD0_BAD0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'b0011;
    d_exp_q.push_back(d_model);
    pulses    = 0;
    valid_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      mem_ack_man = (c == 4);
      @(negedge clk);
      if (c == 0) checkOutput("st_mem_req_c0", {31'b0, mem_req}, 32'd0);
      if (c >= 1 && c <= 4) begin
        checkOutput($sformatf("st_mem_req_c%0d", c), {31'b0, mem_req}, 32'd1);
        checkOutput($sformatf("st_mem_we_c%0d", c), {31'b0, mem_we}, 32'd1);
        checkOutput($sformatf("st_mem_addr_c%0d", c), mem_addr, 32'h200);
        checkOutput($sformatf("st_mem_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
        checkOutput($sformatf("st_mem_wstrb_c%0d", c), {28'b0, mem_wstrb}, 32'h3);
        checkOutput($sformatf("st_d_stall_c%0d", c), {31'b0, d_stall}, 32'd1);
      end
      if (d_valid) begin
        pulses++;
        if (valid_cyc < 0) valid_cyc = c;
        d_req = 1'b0;
        d_we  = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_ack_man = 1'b0;
    checkOutput("st_d_valid_pulses", pulses, 1);
    checkOutput("st_d_valid_cycle", valid_cyc, 5);
    checkOutput("st_d_rdata_kept", d_rdata, d_model);

    // spurious mem_ack while idle must be ignored
    mem_rdata_man = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      mem_ack_man = (c < 2);
      @(negedge clk);
      checkOutput($sformatf("sp_mem_req_c%0d", c), {31'b0, mem_req}, 32'd0);
      checkOutput($sformatf("sp_i_valid_c%0d", c), {31'b0, i_valid}, 32'd0);
      checkOutput($sformatf("sp_d_valid_c%0d", c), {31'b0, d_valid}, 32'd0);
      checkOutput($sformatf("sp_i_rdata_c%0d", c), i_rdata, i_model);
      checkOutput($sformatf("sp_d_rdata_c%0d", c), d_rdata, d_model);
      @(posedge clk); #1;
    end
    mem_ack_man = 1'b0;

    // reset while in GRANT_I, then a late mem_ack
    mem_rdata_man = 32'h1234_ABCD;
    i_req  = 1'b1;
    i_addr = 32'h50;
    @(negedge clk);
    checkOutput("rg_mem_req_c0", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("rg_mem_req_c1", {31'b0, mem_req}, 32'd1);
    checkOutput("rg_mem_addr_c1", mem_addr, 32'h50);
    @(posedge clk); #1;
    reset   = 1'b0;
    i_model = '0;
    d_model = '0;
    for (int c = 2; c < 8; c++) begin
      mem_ack_man = (c == 3);
      @(negedge clk);
      checkOutput($sformatf("rg_mem_req_c%0d", c), {31'b0, mem_req}, 32'd0);
      checkOutput($sformatf("rg_i_valid_c%0d", c), {31'b0, i_valid}, 32'd0);
      checkOutput($sformatf("rg_i_rdata_c%0d", c), i_rdata, 32'd0);
      if (c == 2) begin
        checkOutput("rg_mem_addr", mem_addr, 32'd0);
        checkOutput("rg_d_rdata", d_rdata, 32'd0);
      end
      @(posedge clk); #1;
    end
    mem_ack_man = 1'b0;
    manual_mode = 1'b0;

    // both ports hold requests continuously; fetch must win every fifth grant
    grant_log.delete();
    i_req  = 1'b1;
    i_addr = 32'h400;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h800;
    i_model = memModel(i_addr);
    i_exp_q.push_back(i_model);
    d_model = memModel(d_addr);
    d_exp_q.push_back(d_model);
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (i_valid) begin
        n++;
        if (n < 10) begin
          i_addr  = i_addr + 32'd4;
          i_model = memModel(i_addr);
          i_exp_q.push_back(i_model);
        end
      end
      if (d_valid) begin
        n++;
        if (n < 10) begin
          d_addr  = d_addr + 32'd4;
          d_model = memModel(d_addr);
          d_exp_q.push_back(d_model);
        end
      end
      if (n >= 10) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("sv_completions", n, 10);
    exp_order = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      exp_ch = exp_order[k];
      if (grant_log.size() > k)
        checkOutput($sformatf("sv_order_%0d", k), {24'b0, grant_log[k]}, {24'b0, exp_ch});
      else begin
        checks++;
        failures++;
        $display("[TB] FAIL sv_order_%0d: got no grant, want %c", k, exp_ch);
      end
    end
    checkOutput("sv_i_pending", i_exp_q.size(), 0);
    checkOutput("sv_d_pending", d_exp_q.size(), 1);
    i_exp_q.delete();
    d_exp_q.delete();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
